// File: rtl/wishbone_lsu_master_pkg.sv
`default_nettype none
// ============================================================================
// Module : wishbone_lsu_master_pkg
// Brief  : FSM state encoding and RV32I load/store funct3 codes.
// Rev    : 1.0  initial release
// ============================================================================
package wishbone_lsu_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] c_LB  = 3'b000;
    localparam logic [2:0] c_LH  = 3'b001;
    localparam logic [2:0] c_LW  = 3'b010;
    localparam logic [2:0] c_LBU = 3'b100;
    localparam logic [2:0] c_LHU = 3'b101;
    localparam logic [2:0] c_SB  = 3'b000;
    localparam logic [2:0] c_SH  = 3'b001;
    localparam logic [2:0] c_SW  = 3'b010;

endpackage
`default_nettype wire

// File: rtl/wb_lane_align.sv
`default_nettype none
// ============================================================================
// Module : wb_lane_align
// Brief  : Byte-lane selects, store replication, load extraction/extension
//          and legality check for one load/store access.
// Rev    : 1.0  initial release
// ============================================================================
module wb_lane_align
    import wishbone_lsu_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            i_funct3,
    input  logic                  i_we,
    input  logic [1:0]            i_addr_lo,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [3:0]            o_sel,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_bad
);

    logic [DATA_WIDTH-1:0] w_rsh_b;
    logic [DATA_WIDTH-1:0] w_rsh_h;
    logic                  w_illegal;
    logic                  w_misaligned;

    assign w_rsh_b = i_rdata >> {i_addr_lo, 3'b000};
    assign w_rsh_h = i_rdata >> {i_addr_lo[1], 4'b0000};

    always_comb begin
        if (i_we) begin
            w_illegal = !(i_funct3 == c_SB || i_funct3 == c_SH || i_funct3 == c_SW);
        end else begin
            w_illegal = !(i_funct3 == c_LB || i_funct3 == c_LH || i_funct3 == c_LW ||
                          i_funct3 == c_LBU || i_funct3 == c_LHU);
        end
    end

    assign w_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr_lo[0]) ||
                          ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00));
    assign o_bad        = w_illegal || w_misaligned;

    // funct3[2] set means zero-extend (LBU/LHU); clear means sign-extend.
    always_comb begin
        o_sel   = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        case (i_funct3[1:0])
            2'b00: begin
                o_sel   = 4'b0001 << i_addr_lo;
                o_wdata = {(DATA_WIDTH/8){i_wdata[7:0]}};
                o_rdata = {{(DATA_WIDTH-8){~i_funct3[2] & w_rsh_b[7]}}, w_rsh_b[7:0]};
            end
            2'b01: begin
                o_sel   = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {(DATA_WIDTH/16){i_wdata[15:0]}};
                o_rdata = {{(DATA_WIDTH-16){~i_funct3[2] & w_rsh_h[15]}}, w_rsh_h[15:0]};
            end
            default: begin
                o_sel   = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wishbone_lsu_master.sv
`default_nettype none
// ============================================================================
// Module : wishbone_lsu_master
// Brief  : Single-outstanding RV32I load/store unit driving a Wishbone master
//          port, with alignment checking and an ACK timeout.
// Rev    : 1.0  initial release
// ============================================================================
module wishbone_lsu_master
    import wishbone_lsu_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_REQ,
    input  logic                  i_WE,
    input  logic [2:0]            i_FUNCT3,
    input  logic [ADDR_WIDTH-1:0] i_ADDR,
    input  logic [DATA_WIDTH-1:0] i_WDATA,
    output logic                  o_BUSY,
    output logic                  o_DONE,
    output logic [DATA_WIDTH-1:0] o_RDATA,
    output logic                  o_ERR,
    output logic [ADDR_WIDTH-1:0] o_ADDR,
    output logic [DATA_WIDTH-1:0] o_DATA,
    input  logic [DATA_WIDTH-1:0] i_DATA,
    output logic                  o_WE,
    output logic [3:0]            o_SEL,
    output logic                  o_STB,
    output logic                  o_CYC,
    input  logic                  i_ACK
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_funct3;
    logic [1:0]           r_addr_lo;
    logic                 r_we;

    logic [2:0]           w_funct3;
    logic [1:0]           w_addr_lo;
    logic                 w_we;
    logic [3:0]           w_sel;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                 w_bad;

    // Decode the live request in IDLE, the latched one while on the bus.
    assign w_funct3  = (r_state == ST_IDLE) ? i_FUNCT3    : r_funct3;
    assign w_addr_lo = (r_state == ST_IDLE) ? i_ADDR[1:0] : r_addr_lo;
    assign w_we      = (r_state == ST_IDLE) ? i_WE        : r_we;

    wb_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
        .i_funct3  (w_funct3),
        .i_we      (w_we),
        .i_addr_lo (w_addr_lo),
        .i_wdata   (i_WDATA),
        .i_rdata   (i_DATA),
        .o_sel     (w_sel),
        .o_wdata   (w_wdata),
        .o_rdata   (w_rdata),
        .o_bad     (w_bad)
    );

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_funct3  <= 3'b000;
            r_addr_lo <= 2'b00;
            r_we      <= 1'b0;
            o_BUSY    <= 1'b0;
            o_DONE    <= 1'b0;
            o_RDATA   <= '0;
            o_ERR     <= 1'b0;
            o_ADDR    <= '0;
            o_DATA    <= '0;
            o_WE      <= 1'b0;
            o_SEL     <= 4'b0000;
            o_STB     <= 1'b0;
            o_CYC     <= 1'b0;
        end else begin
            o_DONE <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_REQ) begin
                        r_funct3  <= i_FUNCT3;
                        r_addr_lo <= i_ADDR[1:0];
                        r_we      <= i_WE;
                        r_cnt     <= '0;
                        o_BUSY    <= 1'b1;
                        if (w_bad) begin
                            r_state <= ST_RESP;
                            o_DONE  <= 1'b1;
                            o_ERR   <= 1'b1;
                            o_RDATA <= '0;
                        end else begin
                            r_state <= ST_BUS;
                            o_CYC   <= 1'b1;
                            o_STB   <= 1'b1;
                            o_WE    <= i_WE;
                            o_SEL   <= w_sel;
                            o_DATA  <= w_wdata;
                            o_ADDR  <= {i_ADDR[ADDR_WIDTH-1:2], 2'b00};
                        end
                    end
                end
                ST_BUS: begin
                    // ACK is tested first so it wins over a coincident timeout.
                    if (i_ACK) begin
                        r_state <= ST_RESP;
                        o_CYC   <= 1'b0;
                        o_STB   <= 1'b0;
                        o_WE    <= 1'b0;
                        o_DONE  <= 1'b1;
                        o_ERR   <= 1'b0;
                        o_RDATA <= r_we ? '0 : w_rdata;
                    end else if (r_cnt == c_CNT_W'(TIMEOUT - 1)) begin
                        r_state <= ST_RESP;
                        o_CYC   <= 1'b0;
                        o_STB   <= 1'b0;
                        o_WE    <= 1'b0;
                        o_DONE  <= 1'b1;
                        o_ERR   <= 1'b1;
                        o_RDATA <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    o_BUSY  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    o_BUSY  <= 1'b0;
                    o_CYC   <= 1'b0;
                    o_STB   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wishbone_lsu_master.sv
`default_nettype none
// ============================================================================
// Module : tb_wishbone_lsu_master
// Brief  : Directed self-checking bench for wishbone_lsu_master.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wishbone_lsu_master;

    localparam int c_TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] sdata = '0;
    logic        ack = 1'b0;
    logic        busy, done, err, wb_we, stb, cyc;
    logic [31:0] rdata, wb_addr, wb_data;
    logic [3:0]  sel;

    int n_checks = 0;
    int n_errors = 0;

    wishbone_lsu_master #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .TIMEOUT    (c_TO)
    ) dut (
        .i_CLK    (clk),
        .i_RST    (rst_n),
        .i_REQ    (req),
        .i_WE     (we),
        .i_FUNCT3 (funct3),
        .i_ADDR   (addr),
        .i_WDATA  (wdata),
        .o_BUSY   (busy),
        .o_DONE   (done),
        .o_RDATA  (rdata),
        .o_ERR    (err),
        .o_ADDR   (wb_addr),
        .o_DATA   (wb_data),
        .i_DATA   (sdata),
        .o_WE     (wb_we),
        .o_SEL    (sel),
        .o_STB    (stb),
        .o_CYC    (cyc),
        .i_ACK    (ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a one-cycle request; returns 1 time unit after the accepting edge.
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
        step();
        req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({busy, done, err, wb_we, stb, cyc} !== 6'b0 || sel !== 4'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got busy%b done%b err%b we%b stb%b cyc%b sel%b required all 0",
                     busy, done, err, wb_we, stb, cyc, sel);
        end
        n_checks++;
        if (wb_addr !== 32'h0 || wb_data !== 32'h0 || rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_data: got addr%h data%h rdata%h required 0", wb_addr, wb_data, rdata);
        end
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_lw();
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        n_checks++;
        if (stb !== 1'b1 || cyc !== 1'b1 || sel !== 4'b1111 || wb_addr !== 32'h100 || wb_we !== 1'b0) begin
            n_errors++;
            $display("FAIL lw_bus: got stb%b cyc%b sel%b addr%h we%b required 1 1 1111 00000100 0",
                     stb, cyc, sel, wb_addr, wb_we);
        end
        sdata = 32'hDEADBEEF; ack = 1'b1;
        step();
        ack = 1'b0;
        n_checks++;
        if (done !== 1'b1 || err !== 1'b0 || rdata !== 32'hDEADBEEF || cyc !== 1'b0 || stb !== 1'b0) begin
            n_errors++;
            $display("FAIL lw_done: got done%b err%b rdata%h cyc%b stb%b required 1 0 deadbeef 0 0",
                     done, err, rdata, cyc, stb);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL lw_idle: got done%b busy%b required 0 0", done, busy);
        end
    endtask

    task automatic test_lb_lbu();
        logic [2:0] f3s [2] = '{3'b000, 3'b100};
        logic [31:0] exp [2] = '{32'hFFFFFF80, 32'h00000080};
        for (int i = 0; i < 2; i++) begin
            issue(1'b0, f3s[i], 32'h103, 32'h0);
            n_checks++;
            if (sel !== 4'b1000 || wb_addr !== 32'h100) begin
                n_errors++;
                $display("FAIL lb_sel[%0d]: got sel%b addr%h required 1000 00000100", i, sel, wb_addr);
            end
            sdata = 32'h80FF0000; ack = 1'b1;
            step();
            ack = 1'b0;
            n_checks++;
            if (done !== 1'b1 || rdata !== exp[i] || err !== 1'b0) begin
                n_errors++;
                $display("FAIL lb_rdata[%0d]: got done%b rdata%h err%b required 1 %h 0", i, done, rdata, err, exp[i]);
            end
            step();
        end
    endtask

    task automatic test_sh();
        issue(1'b1, 3'b001, 32'h202, 32'h1234ABCD);
        n_checks++;
        if (sel !== 4'b1100 || wb_data !== 32'hABCDABCD || wb_we !== 1'b1 || wb_addr !== 32'h200) begin
            n_errors++;
            $display("FAIL sh_bus: got sel%b data%h we%b addr%h required 1100 abcdabcd 1 00000200",
                     sel, wb_data, wb_we, wb_addr);
        end
        sdata = 32'hFFFFFFFF; ack = 1'b1;
        step();
        ack = 1'b0;
        n_checks++;
        if (done !== 1'b1 || rdata !== 32'h0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL sh_done: got done%b rdata%h err%b required 1 0 0", done, rdata, err);
        end
        step();
    endtask

    // Misaligned word, misaligned half, illegal store code.
    task automatic test_bad_req();
        logic        ws  [3] = '{1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s [3] = '{3'b010, 3'b001, 3'b100};
        logic [31:0] as  [3] = '{32'h101, 32'h011, 32'h200};
        for (int i = 0; i < 3; i++) begin
            issue(ws[i], f3s[i], as[i], 32'h55);
            n_checks++;
            if (done !== 1'b1 || err !== 1'b1 || cyc !== 1'b0 || stb !== 1'b0 || rdata !== 32'h0) begin
                n_errors++;
                $display("FAIL bad_req[%0d]: got done%b err%b cyc%b stb%b rdata%h required 1 1 0 0 0",
                         i, done, err, cyc, stb, rdata);
            end
            step();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || cyc !== 1'b0 || stb !== 1'b0) begin
                n_errors++;
                $display("FAIL bad_req_after[%0d]: got done%b busy%b cyc%b stb%b required 0 0 0 0",
                         i, done, busy, cyc, stb);
            end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        issue(1'b0, 3'b001, 32'h10, 32'h0);
        sdata = 32'h12345678;
        while (stb === 1'b1 && n < 20) begin
            n++;
            step();
        end
        n_checks++;
        if (n !== c_TO) begin
            n_errors++;
            $display("FAIL timeout_len: got %0d stb cycles required %0d", n, c_TO);
        end
        n_checks++;
        if (done !== 1'b1 || err !== 1'b1 || rdata !== 32'h0 || cyc !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_done: got done%b err%b rdata%h cyc%b required 1 1 0 0", done, err, rdata, cyc);
        end
        step();
    endtask

    // ACK arrives on the last cycle before timeout: it must win.
    task automatic test_ack_at_limit();
        issue(1'b0, 3'b101, 32'h22, 32'h0);
        for (int i = 0; i < c_TO - 1; i++) step();
        n_checks++;
        if (stb !== 1'b1) begin
            n_errors++;
            $display("FAIL limit_stb: got stb%b required 1", stb);
        end
        sdata = 32'h9ABC0000; ack = 1'b1;
        step();
        ack = 1'b0;
        n_checks++;
        if (done !== 1'b1 || err !== 1'b0 || rdata !== 32'h00009ABC) begin
            n_errors++;
            $display("FAIL limit_done: got done%b err%b rdata%h required 1 0 00009abc", done, err, rdata);
        end
        step();
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        issue(1'b0, 3'b010, 32'h400, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (cyc !== 1'b0 || stb !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_async: got cyc%b stb%b busy%b required 0 0 0", cyc, stb, busy);
        end
        step();
        rst_n = 1'b1;
        ack = 1'b1; sdata = 32'h11111111;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1 || stb === 1'b1) dones++;
            step();
        end
        ack = 1'b0;
        n_checks++;
        if (dones !== 0) begin
            n_errors++;
            $display("FAIL abort_nodone: got %0d cycles with done/stb required 0", dones);
        end
        issue(1'b0, 3'b010, 32'h500, 32'h0);
        sdata = 32'hCAFEF00D; ack = 1'b1;
        step();
        ack = 1'b0;
        n_checks++;
        if (done !== 1'b1 || rdata !== 32'hCAFEF00D || err !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_next: got done%b rdata%h err%b required 1 cafef00d 0", done, rdata, err);
        end
        step();
    endtask

    // A held request is ignored in BUS/RESP; the next one issues 3 cycles later.
    task automatic test_back_to_back();
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h300;
        step();
        addr = 32'h600;
        step();
        n_checks++;
        if (stb !== 1'b1 || wb_addr !== 32'h300) begin
            n_errors++;
            $display("FAIL b2b_hold: got stb%b addr%h required 1 00000300", stb, wb_addr);
        end
        sdata = 32'h0; ack = 1'b1;
        step();
        ack = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_done: got done%b busy%b required 1 1", done, busy);
        end
        step();
        n_checks++;
        if (busy !== 1'b0 || stb !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_idle: got busy%b stb%b required 0 0", busy, stb);
        end
        step();
        req = 1'b0;
        n_checks++;
        if (stb !== 1'b1 || wb_addr !== 32'h600) begin
            n_errors++;
            $display("FAIL b2b_next: got stb%b addr%h required 1 00000600", stb, wb_addr);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
    endtask

    initial begin
        #1;
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_bad_req();
        test_timeout();
        test_ack_at_limit();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wishbone_lsu_master.md
WISHBONE_LSU_MASTER -- requirements
Module: wishbone_lsu_master

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, Wishbone data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 256, the maximum number of cycles spent waiting for ACK.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The ports SHALL be as follows:
- i_CLK, input, 1: clock.
- i_RST, input, 1: asynchronous active-low reset.
- i_REQ, input, 1: core load/store request.
- i_WE, input, 1: 1=store, 0=load.
- i_FUNCT3, input, 3: RV32I width/sign code.
- i_ADDR, input, ADDR_WIDTH: core byte address.
- i_WDATA, input, DATA_WIDTH: store data, LSB-aligned.
- o_BUSY, output, 1: transaction in progress.
- o_DONE, output, 1: one-cycle completion strobe.
- o_RDATA, output, DATA_WIDTH: extended load result.
- o_ERR, output, 1: misaligned, illegal or timed-out; valid with o_DONE.
- o_ADDR, output, ADDR_WIDTH: Wishbone byte address, bits [1:0] = 0.
- o_DATA, output, DATA_WIDTH: Wishbone write data.
- i_DATA, input, DATA_WIDTH: Wishbone read data.
- o_WE, output, 1: Wishbone write enable.
- o_SEL, output, 4: Wishbone byte selects.
- o_STB, output, 1: Wishbone strobe.
- o_CYC, output, 1: Wishbone cycle.
- i_ACK, input, 1: Wishbone acknowledge.

Function
REQ-006 The FSM SHALL have three states, IDLE, BUS and RESP, and all Wishbone outputs SHALL be registered.
REQ-007 In IDLE with i_REQ=1, the block SHALL latch its inputs, decode them and go to BUS; if the request is misaligned or illegal, it SHALL go straight to RESP with error=1 and SHALL assert neither CYC nor STB.
REQ-008 Alignment SHALL be checked as follows:
- Halfword with addr[0]=1 is misaligned.
- Word with addr[1:0]!=0 is misaligned.
- Legal loads are 000, 001, 010, 100 and 101.
- Legal stores are 000, 001 and 010.
REQ-009 In BUS, o_CYC and o_STB SHALL both be 1, and o_ADDR, o_WE, o_SEL and o_DATA SHALL be held stable.
REQ-010 o_SEL SHALL be decoded as follows:
- Byte: 4'b0001 << addr[1:0].
- Half: 4'b0011 << {addr[1],1'b0}.
- Word: 4'b1111.
REQ-011 Store data SHALL replicate onto the lanes: the byte ×4 for SB, the halfword ×2 for SH, and the full word for SW.
REQ-012 When i_ACK=1 is sampled in BUS, the block SHALL go to RESP and deassert CYC and STB on the same edge; for loads it SHALL capture the selected lane of i_DATA, sign-extended for funct3 000/001 and zero-extended for 100/101.
REQ-013 A timeout counter SHALL clear on entry to BUS and increment each BUS cycle; on reaching TIMEOUT-1 without ACK, the block SHALL drop CYC and STB and go to RESP with error=1 and o_RDATA=0.
REQ-014 If ACK and timeout occur in the same cycle, the ACK SHALL win.
REQ-015 RESP SHALL last exactly one cycle with o_DONE=1 and o_RDATA/o_ERR valid, then return to IDLE.
REQ-016 o_RDATA SHALL be 0 for stores.
REQ-017 o_BUSY SHALL be 1 whenever the state is not IDLE, and i_REQ SHALL be ignored unless the state is IDLE.
REQ-018 Minimum latency SHALL be: request at cycle 0, STB at cycle 1, ACK at cycle 1, o_DONE at cycle 2.
REQ-019 The maximum issue rate SHALL be one transaction per 3 cycles.

Reset
REQ-020 Reset assertion SHALL asynchronously force:
- State to IDLE.
- o_CYC, o_STB, o_WE, o_DONE, o_ERR and o_BUSY to 0.
- o_SEL to 0.
- o_ADDR, o_DATA and o_RDATA to 0.
- The timeout counter to 0.
REQ-021 A reset asserted during BUS SHALL abort the cycle with no o_DONE, and the aborted transaction SHALL NOT be replayed.

Structure
REQ-022 A shared package SHALL hold the state enum (IDLE/BUS/RESP) and the RV32I funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-023 The combinational lane logic (SEL generation, write replication, read extraction and extension) SHALL be one sub-module, wb_lane_align.

Verification
REQ-024 LW at 0x100 with the slave returning i_DATA=0xDEADBEEF and ACK at cycle 1 -> o_SEL=1111, o_DONE at cycle 2, o_RDATA=0xDEADBEEF, o_ERR=0.
REQ-025 LB at 0x103 with i_DATA=0x80FF_0000 -> o_SEL=1000, o_RDATA=0xFFFFFF80; LBU at the same address -> o_RDATA=0x00000080.
REQ-026 SH at 0x202 with i_WDATA=0x1234ABCD -> o_SEL=1100, o_DATA=0xABCDABCD, o_WE=1, o_RDATA=0 on DONE.
REQ-027 LW at 0x101 -> no CYC/STB ever asserted, o_DONE and o_ERR=1 one cycle after the request.
REQ-028 LH with ACK never asserted and TIMEOUT=8 -> STB high for 8 cycles, then DONE with o_ERR=1 and o_RDATA=0.
REQ-029 i_RST pulled low during BUS -> CYC/STB low immediately (async), no DONE; a following LW completes normally.
